// File: rtl/aes_key_expand_seq_if.sv
// Interface for aes_key_expand_seq: key load request, status and round-10 key.
// AES_KEY_STORE_EN adds the round-key register file read port (rk_rd_addr/rk_rd_data).
// master = key producer / consumer side, slave = the key expander.
interface aes_key_expand_seq_if;
    logic [127:0] key_in;
    logic         key_start;
    logic         busy;
    logic         key_valid;
    logic [127:0] round_key_10;
    logic [3:0]   round_idx;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;

    modport master (
        output key_in, key_start, rk_rd_addr,
        input  busy, key_valid, round_key_10, round_idx, rk_rd_data
    );
    modport slave (
        input  key_in, key_start, rk_rd_addr,
        output busy, key_valid, round_key_10, round_idx, rk_rd_data
    );
`else
    modport master (
        output key_in, key_start,
        input  busy, key_valid, round_key_10, round_idx
    );
    modport slave (
        input  key_in, key_start,
        output busy, key_valid, round_key_10, round_idx
    );
`endif
endinterface

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: one round key per clock, 10 clocks from key_start to
// a stable, valid round-10 key. Optional macro AES_KEY_STORE_EN keeps all 11 round keys
// in a register file with a combinational read port.
module aes_key_expand_seq #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input logic                clk,
    input logic                reset,
    aes_key_expand_seq_if.slave bus
);

    if (NUM_ROUNDS != 10) begin : g_bad_rounds
        $error("aes_key_expand_seq: only NUM_ROUNDS = 10 (AES-128) is supported");
    end

    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e       state_q;
    logic [127:0] work_q;
    logic [127:0] key_d;
    logic [127:0] rk10_q;
    logic [3:0]   round_idx_q;
    logic         busy_q;
    logic         key_valid_q;
    logic         load;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        b    = gf_mul(x252, x2);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Next round key from the working register.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
        w0    = work_q[127:96];
        w1    = work_q[95:64];
        w2    = work_q[63:32];
        w3    = work_q[31:0];
        temp  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_idx_q + 4'd1), 24'h000000};
        n0    = w0 ^ temp;
        n1    = w1 ^ n0;
        n2    = w2 ^ n1;
        n3    = w3 ^ n2;
        key_d = {n0, n1, n2, n3};
    end

    // A start is accepted only when not expanding; busy-time starts are dropped.
    always_comb begin
        load = bus.key_start && (state_q != StExpand);
    end

    // Control FSM with registered outputs; reset has priority over key_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            work_q      <= '0;
            rk10_q      <= '0;
            round_idx_q <= '0;
            busy_q      <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (load) begin
                        work_q      <= bus.key_in;
                        round_idx_q <= '0;
                        key_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StExpand;
                    end
                end
                StExpand: begin
                    work_q      <= key_d;
                    round_idx_q <= round_idx_q + 4'd1;
                    if (round_idx_q == LastIdx) begin
                        rk10_q      <= key_d;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.key_valid    = key_valid_q;
    assign bus.round_key_10 = rk10_q;
    assign bus.round_idx    = round_idx_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_rd;

    // Round-key file: entry 0 at load, entry n as round n is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
        end else if (load) begin
            rk_q[0] <= bus.key_in;
        end else if (state_q == StExpand) begin
            rk_q[round_idx_q + 4'd1] <= key_d;
        end
    end

    // Combinational read; out-of-range addresses return zero.
    always_comb begin
        rk_rd = '0;
        if (bus.rk_rd_addr <= 4'd10) rk_rd = rk_q[bus.rk_rd_addr];
    end

    assign bus.rk_rd_data = rk_rd;
`endif

endmodule
